// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions used by the multiplier and divider.
//   - uops codes for the M-extension multiply and divide operations
//   - divider FSM state encoding
//   - default operand/result and uops widths
package alu_pkg;

  localparam int DEF_W_PD_UOPS = 6;
  localparam int DEF_W_PD_DATA = 32;

  // Multiply uops (pipelined multiplier)
  localparam logic [5:0] UOP_MUL    = 6'b001_000;
  localparam logic [5:0] UOP_MULH   = 6'b001_001;
  localparam logic [5:0] UOP_MULHSU = 6'b001_010;
  localparam logic [5:0] UOP_MULHU  = 6'b001_011;

  // Divide uops (iterative divider): bit0 = unsigned, bit1 = remainder
  localparam logic [5:0] UOP_DIV    = 6'b001_100;
  localparam logic [5:0] UOP_DIVU   = 6'b001_101;
  localparam logic [5:0] UOP_REM    = 6'b001_110;
  localparam logic [5:0] UOP_REMU   = 6'b001_111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem      - current partial remainder (always < dvs)
//   dvd_msb  - next dividend bit to shift in
//   dvs      - divisor
//   rem_next - partial remainder after the trial subtraction
//   q_bit    - quotient bit produced by this step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  // The shifted remainder keeps the bit shifted out of rem as a carry, so
  // divisors with their MSB set still compare correctly.
  logic [W:0] shifted_s;
  logic [W:0] diff_s;

  assign shifted_s = {rem, dvd_msb};
  assign diff_s    = shifted_s - {1'b0, dvs};

  // No borrow out of the trial subtraction means shifted >= dvs.
  assign q_bit    = ~diff_s[W];
  assign rem_next = q_bit ? diff_s[W-1:0] : shifted_s[W-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU uops.
// One quotient bit per cycle; one request in flight; single-cycle result pulse.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   DFI_PD_valid   - request strobe (accepted only when idle and a divide uops)
//   DFI_PD_uops    - operation code
//   DFI_PD_rs/rt   - dividend / divisor
//   DFI_PD_flush   - abort in-flight operation, return to idle
//   DFO_PD_busy    - high while a request is in progress
//   DFO_PD_valid   - one-cycle result strobe
//   DFO_PD_uops    - uops of the completed request
//   DFO_PD_rd      - quotient or remainder
// Build option: DIV_SPECIAL_FASTPATH_EN sends divide-by-zero and signed
// overflow straight from accept to FIX (result two cycles after accept).
module div_unit
  import alu_pkg::*;
#(
  parameter int W_PD_UOPS = DEF_W_PD_UOPS,
  parameter int W_PD_DATA = DEF_W_PD_DATA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DFI_PD_valid,
  input  logic [W_PD_UOPS-1:0] DFI_PD_uops,
  input  logic [W_PD_DATA-1:0] DFI_PD_rs,
  input  logic [W_PD_DATA-1:0] DFI_PD_rt,
  input  logic                 DFI_PD_flush,
  output logic                 DFO_PD_busy,
  output logic                 DFO_PD_valid,
  output logic [W_PD_UOPS-1:0] DFO_PD_uops,
  output logic [W_PD_DATA-1:0] DFO_PD_rd
);

  localparam int W_CNT = (W_PD_DATA > 1) ? $clog2(W_PD_DATA) : 1;
  localparam logic [W_CNT-1:0]     CNT_LAST = W_CNT'(W_PD_DATA - 1);
  localparam logic [W_PD_DATA-1:0] DATA_MIN = {1'b1, {(W_PD_DATA-1){1'b0}}};
  localparam logic [W_PD_DATA-1:0] DATA_ONES = {W_PD_DATA{1'b1}};
  localparam logic [W_PD_DATA-1:0] DATA_ZERO = {W_PD_DATA{1'b0}};

  // Magnitude of a value, treating it as two's complement when sgn_en is set.
  function automatic logic [W_PD_DATA-1:0] mag_f(input logic [W_PD_DATA-1:0] v,
                                                 input logic sgn_en);
    return (sgn_en && v[W_PD_DATA-1]) ? (DATA_ZERO - v) : v;
  endfunction

  // Conditional two's-complement negation.
  function automatic logic [W_PD_DATA-1:0] neg_f(input logic [W_PD_DATA-1:0] v,
                                                 input logic neg_en);
    return neg_en ? (DATA_ZERO - v) : v;
  endfunction

  div_state_e           state_r;
  logic [W_CNT-1:0]     cnt_r;
  logic [W_PD_UOPS-1:0] uops_r;
  logic                 signed_op_r;
  logic                 rem_op_r;
  logic                 sgn_rs_r;
  logic                 sgn_rt_r;
  logic                 dvz_r;
  logic                 ovf_r;
  logic [W_PD_DATA-1:0] rs_raw_r;
  logic [W_PD_DATA-1:0] rem_r;
  logic [W_PD_DATA-1:0] dvd_r;   // dividend in, quotient shifts in from the LSB
  logic [W_PD_DATA-1:0] dvs_r;

  logic                 busy_r;
  logic                 valid_r;
  logic [W_PD_UOPS-1:0] out_uops_r;
  logic [W_PD_DATA-1:0] rd_r;

  logic                 is_div_s;
  logic                 in_signed_s;
  logic                 accept_s;
  logic                 dvz_s;
  logic                 ovf_s;
  logic [W_PD_DATA-1:0] rem_nxt_s;
  logic                 q_bit_s;
  logic [W_PD_DATA-1:0] q_fix_s;
  logic [W_PD_DATA-1:0] r_fix_s;
  logic [W_PD_DATA-1:0] result_s;

  assign is_div_s = (DFI_PD_uops == W_PD_UOPS'(UOP_DIV))  ||
                    (DFI_PD_uops == W_PD_UOPS'(UOP_DIVU)) ||
                    (DFI_PD_uops == W_PD_UOPS'(UOP_REM))  ||
                    (DFI_PD_uops == W_PD_UOPS'(UOP_REMU));
  assign in_signed_s = ~DFI_PD_uops[0];
  assign accept_s = (state_r == ST_IDLE) && DFI_PD_valid && is_div_s && !DFI_PD_flush;
  assign dvz_s = (DFI_PD_rt == DATA_ZERO);
  assign ovf_s = in_signed_s && (DFI_PD_rs == DATA_MIN) && (DFI_PD_rt == DATA_ONES);

  div_step #(.W(W_PD_DATA)) u_step (
    .rem      (rem_r),
    .dvd_msb  (dvd_r[W_PD_DATA-1]),
    .dvs      (dvs_r),
    .rem_next (rem_nxt_s),
    .q_bit    (q_bit_s)
  );

  // Final sign correction and special-case override of the loop result.
  always_comb begin
    q_fix_s  = neg_f(dvd_r, signed_op_r && (sgn_rs_r != sgn_rt_r));
    r_fix_s  = neg_f(rem_r, signed_op_r && sgn_rs_r);
    if (dvz_r) begin
      q_fix_s = DATA_ONES;
      r_fix_s = rs_raw_r;
    end else if (ovf_r) begin
      q_fix_s = DATA_MIN;
      r_fix_s = DATA_ZERO;
    end else begin
      q_fix_s = q_fix_s;
      r_fix_s = r_fix_s;
    end
    result_s = rem_op_r ? r_fix_s : q_fix_s;
  end

  // Divider FSM: accept, iterate, fix up, present result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {W_CNT{1'b0}};
      uops_r      <= {W_PD_UOPS{1'b0}};
      signed_op_r <= 1'b0;
      rem_op_r    <= 1'b0;
      sgn_rs_r    <= 1'b0;
      sgn_rt_r    <= 1'b0;
      dvz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      rs_raw_r    <= DATA_ZERO;
      rem_r       <= DATA_ZERO;
      dvd_r       <= DATA_ZERO;
      dvs_r       <= DATA_ZERO;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      out_uops_r  <= {W_PD_UOPS{1'b0}};
      rd_r        <= DATA_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r <= 1'b0;
          if (accept_s) begin
            uops_r      <= DFI_PD_uops;
            signed_op_r <= in_signed_s;
            rem_op_r    <= DFI_PD_uops[1];
            sgn_rs_r    <= DFI_PD_rs[W_PD_DATA-1];
            sgn_rt_r    <= DFI_PD_rt[W_PD_DATA-1];
            dvz_r       <= dvz_s;
            ovf_r       <= ovf_s;
            rs_raw_r    <= DFI_PD_rs;
            dvd_r       <= mag_f(DFI_PD_rs, in_signed_s);
            dvs_r       <= mag_f(DFI_PD_rt, in_signed_s);
            rem_r       <= DATA_ZERO;
            cnt_r       <= CNT_LAST;
            busy_r      <= 1'b1;
`ifdef DIV_SPECIAL_FASTPATH_EN
            if (dvz_s || ovf_s) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
`else
            state_r     <= ST_CALC;
`endif
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (DFI_PD_flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            rem_r <= rem_nxt_s;
            dvd_r <= {dvd_r[W_PD_DATA-2:0], q_bit_s};
            cnt_r <= cnt_r - W_CNT'(1);
            if (cnt_r == {W_CNT{1'b0}}) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_FIX: begin
          if (DFI_PD_flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            rd_r       <= result_s;
            out_uops_r <= uops_r;
            valid_r    <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign DFO_PD_busy  = busy_r;
  assign DFO_PD_valid = valid_r;
  assign DFO_PD_uops  = out_uops_r;
  assign DFO_PD_rd    = rd_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Stimulus pushes expected
// results (value, uops, arrival cycle) into a queue; a monitor pops and
// compares whenever DFO_PD_valid is seen.
module tb_div_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DFI_PD_valid = 1'b0;
  logic [5:0]  DFI_PD_uops = 6'd0;
  logic [31:0] DFI_PD_rs = 32'd0;
  logic [31:0] DFI_PD_rt = 32'd0;
  logic        DFI_PD_flush = 1'b0;
  logic        DFO_PD_busy;
  logic        DFO_PD_valid;
  logic [5:0]  DFO_PD_uops;
  logic [31:0] DFO_PD_rd;

  div_unit dut (
    .clk(clk), .rst(rst),
    .DFI_PD_valid(DFI_PD_valid), .DFI_PD_uops(DFI_PD_uops),
    .DFI_PD_rs(DFI_PD_rs), .DFI_PD_rt(DFI_PD_rt), .DFI_PD_flush(DFI_PD_flush),
    .DFO_PD_busy(DFO_PD_busy), .DFO_PD_valid(DFO_PD_valid),
    .DFO_PD_uops(DFO_PD_uops), .DFO_PD_rd(DFO_PD_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  uops;
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RISC-V M-extension rules.
  function automatic logic [31:0] ref_rd(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int sa;
    int sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      UOP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      UOP_REMU: return (b == 32'd0) ? a : a % b;
      UOP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      UOP_REM:  return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int lat(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) ||
              (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_FASTPATH_EN
    return special ? 2 : 34;
`else
    return special ? 34 : 34;
`endif
  endfunction

  // Monitor: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && DFO_PD_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1 rd=%h, expected no result (cycle %0d)",
                 DFO_PD_rd, cyc);
      end else begin
        e = sb_q.pop_front();
        check("rd", DFO_PD_rd, e.rd);
        check("uops", {26'd0, DFO_PD_uops}, {26'd0, e.uops});
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Wait for idle, present one request for one cycle.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_res);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (DFO_PD_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: got busy=1 after 100 cycles, expected 0");
    end
    DFI_PD_valid = 1'b1;
    DFI_PD_uops  = op;
    DFI_PD_rs    = a;
    DFI_PD_rt    = b;
    if (expect_res) begin
      e.uops = op;
      e.rd   = ref_rd(op, a, b);
      e.cyc  = cyc + lat(op, a, b);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 DFI_PD_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 120) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL result_timeout: got %0d results missing, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, DFO_PD_busy}, 32'd0);
    check("rst_valid", {31'd0, DFO_PD_valid}, 32'd0);
    check("rst_uops", {26'd0, DFO_PD_uops}, 32'd0);
    check("rst_rd", DFO_PD_rd, 32'd0);
    rst = 1'b0;

    // Directed cases
    issue(UOP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(UOP_REM,  32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(UOP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1);
    issue(UOP_REMU, 32'hFFFF_FFFF, 32'h10, 1'b1);
    issue(UOP_DIVU, 32'd5, 32'd0, 1'b1);
    issue(UOP_REM,  32'hFFFF_FFFB, 32'd0, 1'b1);
    issue(UOP_DIV,  32'hFFFF_FFFB, 32'd0, 1'b1);
    issue(UOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(UOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(UOP_DIVU, 32'h8000_0001, 32'h8000_0000, 1'b1);
    drain();

    // Randomized cases
    for (int i = 0; i < 30; i++) begin
      op = UOP_DIV | 6'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom) | 32'h8000_0000;
        default: b = 32'($urandom);
      endcase
      issue(op, a, b, 1'b1);
    end
    drain();

    // valid held high across busy: second accept only after the first result
    @(negedge clk);
    DFI_PD_valid = 1'b1;
    DFI_PD_uops  = UOP_DIVU;
    DFI_PD_rs    = 32'd1000;
    DFI_PD_rt    = 32'd9;
    n0 = cyc;
    sb_q.push_back('{UOP_DIVU, 32'd111, n0 + 34});
    sb_q.push_back('{UOP_DIVU, 32'd111, n0 + 69});
    repeat (36) @(posedge clk);
    #1 DFI_PD_valid = 1'b0;
    drain();

    // Multiply uops are never accepted
    DFI_PD_valid = 1'b1;
    DFI_PD_uops  = UOP_MUL;
    DFI_PD_rs    = 32'd6;
    DFI_PD_rt    = 32'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mul_ignored_busy", {31'd0, DFO_PD_busy}, 32'd0);
    end
    DFI_PD_valid = 1'b0;

    // Flush at N+10: idle at N+11, no result, then a fresh request works
    issue(UOP_DIVU, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    repeat (9) @(negedge clk);
    DFI_PD_flush = 1'b1;
    @(posedge clk);
    #1 DFI_PD_flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, DFO_PD_busy}, 32'd0);
    issue(UOP_DIVU, 32'd100, 32'd7, 1'b1);
    drain();

    // Asynchronous reset mid-CALC clears every output at once
    issue(UOP_DIV, 32'hFFFF_FF00, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, DFO_PD_busy}, 32'd0);
    check("arst_valid", {31'd0, DFO_PD_valid}, 32'd0);
    check("arst_uops", {26'd0, DFO_PD_uops}, 32'd0);
    check("arst_rd", DFO_PD_rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(UOP_REMU, 32'd100, 32'd7, 1'b1);
    drain();
    repeat (40) @(negedge clk);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL leftover: got %0d pending results, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
